uart_tx_fifo: RTL

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a transmit FIFO in front of it.
// Bytes written with tx_en/tx_ready are queued, then serialised as
// start / data (LSB first) / optional parity / stop bits, DIV clocks per bit.
// Handshake: a byte is taken on any cycle where tx_en=1 and tx_ready=1;
// tx_en while tx_ready=0 is dropped with no effect.
// All outputs come straight from flops; the serial line lags the FSM state
// by one clock, which keeps every bit exactly DIV cycles long.
module uart_tx_fifo #(
    parameter int BAUDRATE   = 115200,
    parameter int CLK_RATE   = 50000000,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [7:0]                        tx_data,
    input  logic                              tx_en,
    output logic                              tx_ready,
    output logic                              tx,
    output logic                              busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);
    localparam int DIV = CLK_RATE / BAUDRATE;
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int BW  = $clog2(STOP_BITS * DIV);

    localparam logic [BW-1:0] BIT_LAST  = BW'(DIV - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS * DIV - 1);
    localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [7:0]    DATA_MASK = 8'((1 << DATA_BITS) - 1);
    localparam logic          ODD_PAR   = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [BW-1:0]  baud_q, baud_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     shift_q, shift_d;
    logic           par_q, par_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           tx_q, tx_d;
    logic           ready_q, ready_d;
    logic           busy_q, busy_d;
    logic [7:0]     mem_q [FIFO_DEPTH];
    logic [7:0]     head;
    logic           push, pop;

    assign head       = mem_q[rd_ptr_q];
    assign push       = tx_en && ready_q;
    assign tx         = tx_q;
    assign tx_ready   = ready_q;
    assign busy       = busy_q;
    assign fifo_count = count_q;

    // Storage only: contents need no reset, the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

    // State register: FSM, baud timing, FIFO bookkeeping and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            tx_q     <= 1'b1;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            tx_q     <= tx_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state: frame sequencing; a pop loads the shifter and restarts the baud phase.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (count_q != '0) begin
                    pop = 1'b1;
                end
            end
            S_START: begin
                if (baud_q == BIT_LAST) begin
                    state_d = S_DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (baud_q == BIT_LAST) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == DATA_LAST) begin
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (baud_q == BIT_LAST) begin
                    state_d = S_STOP;
                    baud_d  = '0;
                end
            end
            S_STOP: begin
                if (baud_q == STOP_LAST) begin
                    state_d = S_IDLE;
                    baud_d  = '0;
                    // Queued data goes straight into the next start bit, no idle gap.
                    if (count_q != '0) begin
                        pop = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
            end
        endcase
        if (pop) begin
            state_d = S_START;
            baud_d  = '0;
            shift_d = head;
            par_d   = (^(head & DATA_MASK)) ^ ODD_PAR;
        end
    end

    // Outputs: line level from the current state, FIFO counters and status flags.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
        ready_d = (count_d < DEPTH_C);
        busy_d  = (state_q != S_IDLE) || (count_d != '0);
        case (state_q)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_q[0];
            S_PARITY: tx_d = par_q;
            default:  tx_d = 1'b1;
        endcase
    end
endmodule
